// File: rtl/sbox_share_scheduler.sv
// Round-robin time-sharing of one masked Skinny S-box between NREQ nibble lanes.
// Define SBOX_SYNCH_CHECK_EN to add the sticky err output that watches sb_synch.
module sbox_share_scheduler #(
   parameter int NREQ    = 4,
   parameter int SHARES  = 3,
   parameter int LATENCY = 11,
   parameter int RAND_W  = 39,
   parameter int IDW     = $clog2(NREQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*4*SHARES-1:0]   req_data,
   input  logic                       rnd_valid,
   output logic                       rnd_ready,
   input  logic [RAND_W-1:0]          rnd_data,
   output logic [4*SHARES-1:0]        sb_in,
   output logic [RAND_W-1:0]          sb_fresh,
   output logic                       sb_rst,
   input  logic [4*SHARES-1:0]        sb_out,
   input  logic                       sb_synch,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [IDW-1:0]             rsp_id,
   output logic [4*SHARES-1:0]        rsp_data
`ifdef SBOX_SYNCH_CHECK_EN
   ,
   output logic                       err
`endif
);

   localparam int DW = 4 * SHARES;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    rr_ptr_nx;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_nx;
   logic [IDW-1:0]    idx;
   logic [IDW-1:0]    gnt;
   logic              gnt_hit;
   logic              fire;
   logic              last;

   logic [DW-1:0]     sb_in_nx;
   logic [RAND_W-1:0] sb_fresh_nx;
   logic              sb_rst_nx;
   logic              rsp_valid_nx;
   logic [IDW-1:0]    rsp_id_nx;
   logic [DW-1:0]     rsp_data_nx;

   // Lowest cyclic offset from rr_ptr wins: later (smaller k) iterations override.
   always_comb begin
      idx     = '0;
      gnt     = '0;
      gnt_hit = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IDW'((int'(rr_ptr) + k) % NREQ);
         if (req_valid[idx]) begin
            gnt_hit = 1'b1;
            gnt     = idx;
         end
      end
   end

   assign fire      = (state == IDLE) && gnt_hit && rnd_valid;
   assign rnd_ready = fire;
   assign last      = (cnt == CW'(LATENCY - 1));

   always_comb begin
      req_ready = '0;
      if (fire) begin
         req_ready[gnt] = 1'b1;
      end
   end

   always_comb begin
      state_nx     = state;
      rr_ptr_nx    = rr_ptr;
      cnt_nx       = cnt;
      sb_in_nx     = sb_in;
      sb_fresh_nx  = sb_fresh;
      sb_rst_nx    = sb_rst;
      rsp_valid_nx = rsp_valid;
      rsp_id_nx    = rsp_id;
      rsp_data_nx  = rsp_data;
      unique case (state)
         IDLE: begin
            if (fire) begin
               state_nx    = BUSY;
               cnt_nx      = '0;
               sb_in_nx    = req_data[int'(gnt)*DW +: DW];
               sb_fresh_nx = rnd_data;
               sb_rst_nx   = 1'b0;
               rsp_id_nx   = gnt;
               rr_ptr_nx   = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            end
         end
         BUSY: begin
            cnt_nx = cnt + 1'b1;
            if (last) begin
               state_nx     = RESP;
               cnt_nx       = '0;
               rsp_data_nx  = sb_out;
               rsp_valid_nx = 1'b1;
               sb_rst_nx    = 1'b1;
               sb_in_nx     = '0;
               sb_fresh_nx  = '0;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nx     = IDLE;
               rsp_valid_nx = 1'b0;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cnt       <= '0;
         sb_in     <= '0;
         sb_fresh  <= '0;
         sb_rst    <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         state     <= state_nx;
         rr_ptr    <= rr_ptr_nx;
         cnt       <= cnt_nx;
         sb_in     <= sb_in_nx;
         sb_fresh  <= sb_fresh_nx;
         sb_rst    <= sb_rst_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_id    <= rsp_id_nx;
         rsp_data  <= rsp_data_nx;
      end
   end

`ifdef SBOX_SYNCH_CHECK_EN
   // The S-box must report Synch exactly in the final evaluation cycle.
   logic synch_exp;
   assign synch_exp = (state == BUSY) && last;

   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (sb_synch != synch_exp) begin
         err <= 1'b1;
      end
   end
`else
   logic unused_synch;
   assign unused_synch = sb_synch;
`endif

endmodule

// File: tb/tb_sbox_share_scheduler.sv
// Randomized bench for sbox_share_scheduler with a behavioural S-box and
// round-robin reference model.
module tb_sbox_share_scheduler;

   localparam int NREQ = 4;
   localparam int SH   = 3;
   localparam int LAT  = 11;
   localparam int RW   = 39;
   localparam int DW   = 4 * SH;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*DW-1:0] req_data;
   logic              rnd_valid;
   logic              rnd_ready;
   logic [RW-1:0]     rnd_data;
   logic [DW-1:0]     sb_in;
   logic [RW-1:0]     sb_fresh;
   logic              sb_rst;
   logic [DW-1:0]     sb_out;
   logic              sb_synch;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic [DW-1:0]     rsp_data;
`ifdef SBOX_SYNCH_CHECK_EN
   logic              err;
`endif

   int checks = 0;
   int errors = 0;
   int exp_ptr = 0;
   int sbcnt = 0;
   logic force_synch = 1'b0;

   always #5 clk = ~clk;

   sbox_share_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
      .rnd_data  (rnd_data),
      .sb_in     (sb_in),
      .sb_fresh  (sb_fresh),
      .sb_rst    (sb_rst),
      .sb_out    (sb_out),
      .sb_synch  (sb_synch),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
`ifdef SBOX_SYNCH_CHECK_EN
      ,
      .err       (err)
`endif
   );

   function automatic logic [3:0] s4(input logic [3:0] x);
      logic [63:0] t;
      t = 64'hF7E4D583B2A1096C;
      return t[int'(x)*4 +: 4];
   endfunction

   // Unmasked value x = s0^s1^s2; output shares recombine to S(x).
   function automatic logic [DW-1:0] sbox_ref(input logic [DW-1:0] s,
                                              input logic [RW-1:0] f);
      logic [3:0] x, o0, o1, o2;
      x  = s[3:0] ^ s[7:4] ^ s[11:8];
      o1 = s[7:4] ^ f[3:0];
      o2 = s[11:8] ^ f[7:4];
      o0 = s4(x) ^ o1 ^ o2;
      return {o2, o1, o0};
   endfunction

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (((v >> ((ptr + k) % NREQ)) & 4'd1) != 4'd0) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   // Behavioural non-pipelined S-box: result valid only in its last cycle.
   always @(posedge clk) begin
      if (sb_rst !== 1'b0) sbcnt <= 0;
      else sbcnt <= sbcnt + 1;
   end

   assign sb_out = (sb_rst === 1'b0 && sbcnt == LAT - 1) ?
                   sbox_ref(sb_in, sb_fresh) : ~sbox_ref(sb_in, sb_fresh);
   assign sb_synch = (sb_rst === 1'b0 && sbcnt == LAT - 1) || force_synch;

   task automatic rand_inputs();
      req_data[31:0]  = $urandom;
      req_data[47:32] = 16'($urandom);
      rnd_data[31:0]  = $urandom;
      rnd_data[38:32] = 7'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks += 5;
      if (sb_rst !== 1'b1) begin errors++; $display("FAIL reset_sb_rst: got %b want 1", sb_rst); end
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      if (rnd_ready !== 1'b0) begin errors++; $display("FAIL reset_rnd_ready: got %b want 0", rnd_ready); end
      if (sb_in !== 12'h0) begin errors++; $display("FAIL reset_sb_in: got %h want 0", sb_in); end
`ifdef SBOX_SYNCH_CHECK_EN
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
`endif
      rst = 1'b0;
      exp_ptr = 0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int g, n;
      logic [DW-1:0] sh, er;
      logic [RW-1:0] rn;
      rand_inputs();
      req_valid = 4'b0100; rnd_valid = 1'b1; rsp_ready = 1'b1;
      g = rr_pick(req_valid, exp_ptr);
      sh = req_data[g*DW +: DW]; rn = rnd_data; er = sbox_ref(sh, rn);
      #1;
      checks += 2;
      if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL single_req_ready: got %b want %b", req_ready, 4'(1 << g)); end
      if (rnd_ready !== 1'b1) begin errors++; $display("FAIL single_rnd_ready: got %b want 1", rnd_ready); end
      @(negedge clk);
      req_valid = 4'b0; rnd_valid = 1'b0; rand_inputs();
      n = 1;
      while (rsp_valid !== 1'b1 && n < 30) begin
         checks++;
         if (sb_in !== sh || sb_fresh !== rn || sb_rst !== 1'b0) begin
            errors++; $display("FAIL single_hold: sb_in %h fresh %h rst %b want %h %h 0", sb_in, sb_fresh, sb_rst, sh, rn);
         end
         @(negedge clk); n++;
      end
      checks += 3;
      if (n !== LAT + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", n, LAT + 1); end
      if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
      if (rsp_data !== er) begin errors++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, er); end
      exp_ptr = (g + 1) % NREQ;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || sb_rst !== 1'b1) begin errors++; $display("FAIL single_idle: rsp_valid %b sb_rst %b want 0 1", rsp_valid, sb_rst); end
   endtask

   task automatic test_back_to_back();
      int qid[$];
      logic [DW-1:0] qd[$];
      int order[5] = '{0, 1, 2, 3, 0};
      int ngr = 0, nrsp = 0, lastg = 0, g, eid;
      logic [DW-1:0] ed;
      rst = 1'b1; @(negedge clk); rst = 1'b0; exp_ptr = 0;
      req_valid = 4'b1111; rnd_valid = 1'b1; rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 100 && nrsp < 5; cyc++) begin
         if (rsp_valid === 1'b1) begin
            checks++;
            if (qid.size() == 0) begin
               errors++; $display("FAIL b2b_spurious_rsp: got id %0d want none", rsp_id);
            end else begin
               eid = qid.pop_front(); ed = qd.pop_front();
               if (rsp_id !== 2'(eid) || rsp_data !== ed) begin
                  errors++; $display("FAIL b2b_rsp: got %0d/%h want %0d/%h", rsp_id, rsp_data, eid, ed);
               end
            end
            nrsp++;
         end
         rand_inputs();
         if (ngr >= 5) req_valid = 4'b0;
         #1;
         if (req_ready !== 4'b0 && ngr < 5) begin
            g = rr_pick(req_valid, exp_ptr);
            checks += 2;
            if (req_ready !== 4'(1 << g) || rnd_ready !== 1'b1) begin errors++; $display("FAIL b2b_grant: got %b want %b", req_ready, 4'(1 << g)); end
            if (req_ready !== 4'(1 << order[ngr])) begin errors++; $display("FAIL b2b_order: got %b want %b", req_ready, 4'(1 << order[ngr])); end
            if (ngr > 0) begin
               checks++;
               if (cyc - lastg != LAT + 2) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - lastg, LAT + 2); end
            end
            lastg = cyc;
            qid.push_back(g);
            qd.push_back(sbox_ref(req_data[g*DW +: DW], rnd_data));
            exp_ptr = (g + 1) % NREQ;
            ngr++;
         end
         @(negedge clk);
      end
      checks++;
      if (ngr != 5 || nrsp != 5) begin errors++; $display("FAIL b2b_count: got %0d grants %0d rsps want 5 5", ngr, nrsp); end
      req_valid = 4'b0; rnd_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_no_rand();
      int g, n;
      logic [DW-1:0] er;
      rand_inputs();
      req_valid = 4'b0001; rnd_valid = 1'b0; rsp_ready = 1'b1;
      repeat (20) begin
         #1;
         checks++;
         if (req_ready !== 4'b0 || rnd_ready !== 1'b0 || sb_rst !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL norand_idle: req_ready %b rnd_ready %b sb_rst %b want 0 0 1", req_ready, rnd_ready, sb_rst);
         end
         @(negedge clk);
      end
      rnd_valid = 1'b1;
      g = rr_pick(req_valid, exp_ptr);
      er = sbox_ref(req_data[g*DW +: DW], rnd_data);
      #1;
      checks++;
      if (req_ready !== 4'b0001 || rnd_ready !== 1'b1) begin errors++; $display("FAIL norand_grant: got %b/%b want 0001/1", req_ready, rnd_ready); end
      @(negedge clk);
      req_valid = 4'b0; rnd_valid = 1'b0;
      checks++;
      if (sb_rst !== 1'b0) begin errors++; $display("FAIL norand_busy: sb_rst %b want 0", sb_rst); end
      n = 1;
      while (rsp_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (n != LAT + 1 || rsp_id !== 2'(g) || rsp_data !== er) begin
         errors++; $display("FAIL norand_rsp: got n=%0d %0d/%h want %0d %0d/%h", n, rsp_id, rsp_data, LAT + 1, g, er);
      end
      exp_ptr = (g + 1) % NREQ;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int g, n;
      logic [DW-1:0] er;
      rand_inputs();
      req_valid = 4'($urandom_range(1, 15)); rnd_valid = 1'b1; rsp_ready = 1'b0;
      g = rr_pick(req_valid, exp_ptr);
      er = sbox_ref(req_data[g*DW +: DW], rnd_data);
      @(negedge clk);
      req_valid = 4'b1111;
      n = 1;
      while (rsp_valid !== 1'b1 && n < 30) begin
         rand_inputs(); #1;
         checks++;
         if (req_ready !== 4'b0 || rnd_ready !== 1'b0) begin errors++; $display("FAIL bp_busy_grant: got %b/%b want 0/0", req_ready, rnd_ready); end
         @(negedge clk); n++;
      end
      repeat (7) begin
         rand_inputs(); #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_data !== er || req_ready !== 4'b0 || rnd_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold: got v%b %0d/%h rr %b want v1 %0d/%h rr 0", rsp_valid, rsp_id, rsp_data, req_ready, g, er);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1; req_valid = 4'b0; rnd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || sb_rst !== 1'b1) begin errors++; $display("FAIL bp_release: rsp_valid %b sb_rst %b want 0 1", rsp_valid, sb_rst); end
      exp_ptr = (g + 1) % NREQ;
`ifdef SBOX_SYNCH_CHECK_EN
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL bp_err_clean: got %b want 0", err); end
`endif
   endtask

   task automatic test_reset_busy();
      int n;
      logic [DW-1:0] er;
      rand_inputs();
      req_valid = 4'b0100; rnd_valid = 1'b1; rsp_ready = 1'b1;
      #1;
      checks++;
      if (rnd_ready !== 1'b1) begin errors++; $display("FAIL rb_grant: got %b want 1", rnd_ready); end
      @(negedge clk);
      req_valid = 4'b0; rnd_valid = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (sb_rst !== 1'b0) begin errors++; $display("FAIL rb_busy: sb_rst %b want 0", sb_rst); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (sb_rst !== 1'b1 || rsp_valid !== 1'b0 || sb_in !== 12'h0) begin
         errors++; $display("FAIL rb_idle: sb_rst %b rsp_valid %b sb_in %h want 1 0 0", sb_rst, rsp_valid, sb_in);
      end
      repeat (15) begin
         checks++;
         if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rb_no_rsp: got %b want 0", rsp_valid); end
         @(negedge clk);
      end
      exp_ptr = 0;
      rand_inputs();
      req_valid = 4'b1111; rnd_valid = 1'b1;
      er = sbox_ref(req_data[0 +: DW], rnd_data);
      #1;
      checks++;
      if (req_ready !== 4'(1 << rr_pick(req_valid, exp_ptr))) begin errors++; $display("FAIL rb_ptr: got %b want 0001", req_ready); end
      @(negedge clk);
      req_valid = 4'b0; rnd_valid = 1'b0;
      n = 1;
      while (rsp_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== er) begin
         errors++; $display("FAIL rb_rsp: got v%b %0d/%h want v1 0/%h", rsp_valid, rsp_id, rsp_data, er);
      end
      exp_ptr = 1;
      @(negedge clk);
`ifdef SBOX_SYNCH_CHECK_EN
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL rb_err_clean: got %b want 0", err); end
      force_synch = 1'b1;
      @(negedge clk);
      force_synch = 1'b0;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL rb_err_set: got %b want 1", err); end
      repeat (5) @(negedge clk);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL rb_err_sticky: got %b want 1", err); end
`endif
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_data = '0; rnd_valid = 1'b0;
      rnd_data = '0; rsp_ready = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_no_rand();
      test_backpressure();
      test_reset_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
